bcd_seq_arbiter: RTL and testbench
==================================

# bcd_seq_arbiter

Iterative binary-to-BCD conversion engine shared by two requesters. It accepts an 8-bit binary value from one of two valid/ready request ports, picks between them by round-robin, and converts the value with the shift-and-add-3 (double dabble) algorithm, one bit per clock over 8 cycles. It returns hundreds/tens/ones digits plus the requester ID on a valid/ready result port. It replaces two parallel combinational converters in the display path with one small sequential engine.

## Interface
Parameters: none (data width fixed at 8 bits, 3 BCD digits, 2 requesters).

Ports:
- clk  in  1  rising-edge clock, single domain
- rst_n  in  1  synchronous reset, active-low
- req0_valid  in  1  requester 0 has data
- req0_data  in  8  requester 0 binary value
- req0_ready  out  1  requester 0 data accepted this cycle
- req1_valid  in  1  requester 1 has data
- req1_data  in  8  requester 1 binary value
- req1_ready  out  1  requester 1 data accepted this cycle
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_id  out  1  requester index of current result
- out_hund  out  4  hundreds digit, 0..2
- out_tens  out  4  tens digit, 0..9
- out_ones  out  4  ones digit, 0..9

## Operation
- FSM states: IDLE, CONV, DONE. Reset state is IDLE.
- Priority register `prio` (1 bit) names the favoured requester. Reset value is 0.
- IDLE: ready signals are combinational:
  - req0_ready = IDLE & req0_valid & (!req1_valid | prio==0)
  - req1_ready = IDLE & req1_valid & (!req0_valid | prio==1)
  - At most one ready is high in any cycle.
- On a handshake (valid & ready):
  - Latch data into the 8-bit shift register.
  - Clear the 12-bit BCD accumulator.
  - Latch the granted index.
  - Set prio = ~granted.
  - Clear the bit counter.
  - Go to CONV.
- CONV: each cycle, for each digit of hundreds/tens/ones:
  - If the digit is >= 5, add 3 (4-bit add, no carry out).
  - Then shift {hund,tens,ones,shift} left by 1.
  - Increment the counter. After the 8th shift (counter==7), go to DONE.
- DONE, on entry:
  - Register the digits onto out_hund/out_tens/out_ones and the index onto out_id.
  - Assert out_valid.
  - Hold everything stable while out_ready is low.
  - On out_valid & out_ready: deassert out_valid and return to IDLE.
- Result fields keep their last value after the handshake until the next DONE entry.
- No request is accepted outside IDLE. Requesters hold valid/data until they see ready.
- Reset mid-operation (rst_n low in any state): the next edge forces IDLE, out_valid=0, prio=0, digits/out_id=0, counter=0. The in-flight conversion is discarded and no result is emitted.

## Timing
- Reset values:
  - req0_ready=0 and req1_ready=0 while rst_n is low.
  - out_valid=0, out_id=0, out_hund=out_tens=out_ones=0.
- Accept at edge k (IDLE→CONV). Shifts occur at edges k+1..k+8. The DONE entry at edge k+8 also registers the outputs, so out_valid is high in the cycle after edge k+8.
- Latency: 8 cycles from the accept edge to out_valid.
- With out_ready tied high:
  - The result handshake completes at edge k+9, returning to IDLE.
  - The earliest next accept is at edge k+10.
  - Throughput is 1 conversion per 10 cycles.
- out_ready high before out_valid has no effect. out_valid never drops without a handshake, except on reset.
- Both valid in IDLE: the prio requester wins, then priority alternates. A lone requester is granted back-to-back regardless of prio.

## Test plan
- Reset, then req0 sends 8'd255 with out_ready=1 → out_valid 8 cycles after the accept edge, digits 2/5/5, out_id=0, req0_ready high exactly one cycle.
- Corner values in sequence 0, 9, 10, 99, 100, 199, 200 → 0/0/0, 0/0/9, 0/1/0, 0/9/9, 1/0/0, 1/9/9, 2/0/0. Then an exhaustive sweep 0..255 on both ports against a reference model.
- Both req valid continuously after reset, data 8'd12 (req0) and 8'd34 (req1) → grants alternate req0, req1, req0…; out_id alternates 0,1,0; results 0/1/2 and 0/3/4; accepts spaced 10 cycles.
- out_ready held low 20 cycles after out_valid with 8'd128 → out_valid and 1/2/8 stable throughout, req*_ready stay 0. Raise out_ready → handshake, IDLE next cycle.
- rst_n low for one cycle at CONV cycle 4 of 8'd200 → out_valid never asserts for that request, outputs 0, prio=0. With both valid pending afterwards, req0 is granted first.
- Only req1 valid, 3 consecutive values (7, 42, 250) → all granted to req1, out_id=1, results 0/0/7, 0/4/2, 2/5/0.

Source files
------------

// File: rtl/bcd_seq_arbiter_if.sv
// rtl/bcd_seq_arbiter_if.sv - request/result handshake bundle for the shared BCD engine
interface bcd_seq_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_id;
  logic [3:0] out_hund;
  logic [3:0] out_tens;
  logic [3:0] out_ones;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_id, out_hund, out_tens, out_ones
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_id, out_hund, out_tens, out_ones
  );
endinterface

// File: rtl/bcd_seq_arbiter.sv
// rtl/bcd_seq_arbiter.sv - round-robin shared 8-bit binary to 3-digit BCD double-dabble engine
module bcd_seq_arbiter (
  input  logic              clk,
  input  logic              rst_n,
  bcd_seq_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic        out_valid_q, out_valid_d;
  logic        out_id_q, out_id_d;
  logic [11:0] out_bcd_q, out_bcd_d;

  logic        grant0, grant1;
  logic [11:0] adj;
  logic [19:0] shifted;

  // Ready is gated by rst_n so no handshake can complete on the reset edge.
  assign grant0 = (state_q == IDLE) & rst_n & bus.req0_valid & (~bus.req1_valid | ~prio_q);
  assign grant1 = (state_q == IDLE) & rst_n & bus.req1_valid & (~bus.req0_valid |  prio_q);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end
    shifted = {adj, shift_q} << 1;
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_bcd_d   = out_bcd_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          shift_d = grant1 ? bus.req1_data : bus.req0_data;
          bcd_d   = 12'd0;
          id_d    = grant1;
          prio_d  = ~grant1;
          cnt_d   = 3'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = shifted[19:8];
        shift_d = shifted[7:0];
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // The eighth shift and the result register load share one edge.
          out_bcd_d   = shifted[19:8];
          out_id_d    = id_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      shift_q     <= 8'd0;
      bcd_q       <= 12'd0;
      cnt_q       <= 3'd0;
      id_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_bcd_q   <= 12'd0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_bcd_q   <= out_bcd_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_id     = out_id_q;
  assign bus.out_hund   = out_bcd_q[11:8];
  assign bus.out_tens   = out_bcd_q[7:4];
  assign bus.out_ones   = out_bcd_q[3:0];
endmodule

// File: tb/tb_bcd_seq_arbiter.sv
// tb/tb_bcd_seq_arbiter.sv - directed self-checking bench for the shared BCD engine
module tb_bcd_seq_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  bcd_seq_arbiter_if bif ();

  bcd_seq_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bcd_ref(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [11:0] digits();
    return {bif.out_hund, bif.out_tens, bif.out_ones};
  endfunction

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!bif.out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Lone request on port p with out_ready high; checks grant, latency, result, handshake.
  task automatic send(input bit p, input logic [7:0] v, input logic [11:0] exp, input string tag);
    int n;
    if (p) begin bif.req1_valid = 1'b1; bif.req1_data = v; end
    else   begin bif.req0_valid = 1'b1; bif.req0_data = v; end
    #1;
    n = 0;
    while (!(p ? bif.req1_ready : bif.req0_ready) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("%s grant", tag), {31'd0, p ? bif.req1_ready : bif.req0_ready}, 32'd1);
    @(posedge clk); #1;
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    chk($sformatf("%s ready_drop", tag), {31'd0, bif.req0_ready | bif.req1_ready}, 32'd0);
    wait_out_valid(n);
    chk($sformatf("%s latency", tag), n, 32'd8);
    chk($sformatf("%s id", tag), {31'd0, bif.out_id}, {31'd0, p});
    chk($sformatf("%s digits", tag), {20'd0, digits()}, {20'd0, exp});
    @(posedge clk); #1;
    chk($sformatf("%s handshake", tag), {31'd0, bif.out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int t_prev;
    bit seen;
    logic [7:0]  corner_v [7];
    logic [11:0] corner_e [7];
    corner_v = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd200};
    corner_e = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h199, 12'h200};

    rst_n = 1'b0;
    bif.out_ready = 1'b0;
    bif.req0_valid = 1'b0; bif.req0_data = 8'd0;
    bif.req1_valid = 1'b0; bif.req1_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    bif.req0_valid = 1'b1; bif.req1_valid = 1'b1;
    #1;
    chk("rst req0_ready", {31'd0, bif.req0_ready}, 32'd0);
    chk("rst req1_ready", {31'd0, bif.req1_ready}, 32'd0);
    chk("rst out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("rst out_id", {31'd0, bif.out_id}, 32'd0);
    chk("rst digits", {20'd0, digits()}, 32'd0);
    bif.req0_valid = 1'b0; bif.req1_valid = 1'b0;
    rst_n = 1'b1;
    bif.out_ready = 1'b1;
    @(posedge clk); #1;

    send(1'b0, 8'd255, 12'h255, "v255");
    for (int i = 0; i < 7; i++) send(1'b0, corner_v[i], corner_e[i], $sformatf("corner%0d", i));

    // Alternating grants with both requesters continuously valid.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bif.req0_valid = 1'b1; bif.req0_data = 8'd12;
    bif.req1_valid = 1'b1; bif.req1_data = 8'd34;
    #1;
    t_prev = 0;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (!(bif.req0_ready | bif.req1_ready) && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("arb%0d r0", g), {31'd0, bif.req0_ready}, {31'd0, (g % 2) == 0});
      chk($sformatf("arb%0d r1", g), {31'd0, bif.req1_ready}, {31'd0, (g % 2) == 1});
      if (g > 0) chk($sformatf("arb%0d spacing", g), cyc - t_prev, 32'd10);
      t_prev = cyc;
      @(posedge clk); #1;
      if (g == 2) begin bif.req0_valid = 1'b0; bif.req1_valid = 1'b0; end
      wait_out_valid(n);
      chk($sformatf("arb%0d latency", g), n, 32'd8);
      chk($sformatf("arb%0d id", g), {31'd0, bif.out_id}, {31'd0, (g % 2) == 1});
      chk($sformatf("arb%0d digits", g), {20'd0, digits()}, (g % 2) ? 32'h034 : 32'h012);
    end
    @(posedge clk); #1;
    chk("arb handshake", {31'd0, bif.out_valid}, 32'd0);

    // Result stall with out_ready low and both requesters pending.
    bif.out_ready = 1'b0;
    bif.req0_valid = 1'b1; bif.req0_data = 8'd128;
    #1;
    chk("stall grant", {31'd0, bif.req0_ready}, 32'd1);
    @(posedge clk); #1;
    bif.req1_valid = 1'b1; bif.req1_data = 8'd77;
    wait_out_valid(n);
    chk("stall latency", n, 32'd8);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("stall%0d valid", i), {31'd0, bif.out_valid}, 32'd1);
      chk($sformatf("stall%0d digits", i), {20'd0, digits()}, 32'h128);
      chk($sformatf("stall%0d ready", i), {31'd0, bif.req0_ready | bif.req1_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bif.out_ready = 1'b1;
    bif.req0_valid = 1'b0; bif.req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("stall handshake", {31'd0, bif.out_valid}, 32'd0);
    chk("stall hold digits", {20'd0, digits()}, 32'h128);
    bif.req0_valid = 1'b1;
    #1;
    chk("stall idle", {31'd0, bif.req0_ready}, 32'd1);
    bif.req0_valid = 1'b0;
    #1;

    // Reset during conversion discards the in-flight request.
    bif.req0_valid = 1'b1; bif.req0_data = 8'd200;
    #1;
    chk("rstmid grant", {31'd0, bif.req0_ready}, 32'd1);
    @(posedge clk); #1;
    bif.req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmid digits", {20'd0, digits()}, 32'd0);
    chk("rstmid id", {31'd0, bif.out_id}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bif.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("rstmid no_result", {31'd0, seen}, 32'd0);
    bif.req0_valid = 1'b1; bif.req0_data = 8'd5;
    bif.req1_valid = 1'b1; bif.req1_data = 8'd6;
    #1;
    chk("rstmid prio r0", {31'd0, bif.req0_ready}, 32'd1);
    chk("rstmid prio r1", {31'd0, bif.req1_ready}, 32'd0);
    @(posedge clk); #1;
    bif.req0_valid = 1'b0; bif.req1_valid = 1'b0;
    wait_out_valid(n);
    chk("rstmid next id", {31'd0, bif.out_id}, 32'd0);
    chk("rstmid next digits", {20'd0, digits()}, 32'h005);
    @(posedge clk); #1;

    send(1'b1, 8'd7, 12'h007, "lone7");
    send(1'b1, 8'd42, 12'h042, "lone42");
    send(1'b1, 8'd250, 12'h250, "lone250");

    for (int v = 0; v < 256; v++) begin
      send(1'b0, 8'(v), bcd_ref(v), $sformatf("sweep0_%0d", v));
      send(1'b1, 8'(v), bcd_ref(v), $sformatf("sweep1_%0d", v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
